// File: rtl/spi_pkg.sv
// Shared widths, FSM state type and default fill byte for the SPI peripheral transmit path.
package spi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [BYTE_W-1:0] FILL_DEFAULT = 8'h00;

    typedef enum logic {
        StIdle,
        StActive
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, followed by a registered copy for edge detection.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_s & ~prev_q;
    assign fall_o = ~sync_s & prev_q;

endmodule

// File: rtl/spi_tx.sv
// SPI mode-0 peripheral transmitter: oversamples sck/csn in the system clock domain and shifts
// bytes from a one-entry holding buffer onto MISO, MSB first, substituting FILL on underrun.
module spi_tx import spi_pkg::*; #(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] FILL        = FILL_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck_i,
    input  logic              spi_csn_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    input  logic [BYTE_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              underrun_o,
    output logic              busy_o
);

    logic sck_rise, sck_fall;
    logic cs_rise, cs_fall;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_sck_i),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_csn_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (spi_csn_i),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shifter_q, shifter_d;
    logic [BYTE_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              src_buf_q, src_buf_d;
    logic              pend_q, pend_d;
    logic              miso_q, miso_d;
    logic              underrun_q, underrun_d;

    logic wr_en;
    logic commit_buf;
    logic do_peek;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shifter_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            src_buf_q  <= 1'b0;
            pend_q     <= 1'b0;
            miso_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shifter_q  <= shifter_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            src_buf_q  <= src_buf_d;
            pend_q     <= pend_d;
            miso_q     <= miso_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shifter_d  = shifter_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        src_buf_d  = src_buf_q;
        pend_d     = pend_q;
        underrun_d = 1'b0;
        commit_buf = 1'b0;
        do_peek    = 1'b0;
        wr_en      = tx_valid_i & ~buf_full_q;

        if (wr_en) begin
            buf_d      = tx_data_i;
            buf_full_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    do_peek   = 1'b1;
                    state_d   = StActive;
                    bit_cnt_d = '0;
                end
            end
            StActive: begin
                // Deselect wins over any sck edge seen in the same cycle.
                if (cs_rise) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    pend_d    = 1'b0;
                end else begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (pend_q) begin
                            pend_d = 1'b0;
                            if (src_buf_q) begin
                                commit_buf = 1'b1;
                            end else begin
                                underrun_d = 1'b1;
                            end
                        end
                    end
                    if (sck_fall) begin
                        if (bit_cnt_q == '0) begin
                            do_peek = 1'b1;
                        end else begin
                            shifter_d = {shifter_q[BYTE_W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (commit_buf) begin
            buf_full_d = 1'b0;
        end

        // A peek only stages the byte; the buffer is released at the following sck rise.
        if (do_peek) begin
            shifter_d = buf_full_q ? buf_q : FILL;
            src_buf_d = buf_full_q;
            pend_d    = 1'b1;
        end

        miso_d = ((state_q == StActive) && !cs_rise) ? shifter_q[BYTE_W-1] : 1'b0;
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = (state_q == StActive);
    assign busy_o        = (state_q == StActive);
    assign tx_ready_o    = ~buf_full_q;
    assign underrun_o    = underrun_q;

    a_no_write_on_commit: assert property (
        @(posedge clk) disable iff (!rst_n) !(wr_en && commit_buf)
    );

    a_commit_needs_full: assert property (
        @(posedge clk) disable iff (!rst_n) commit_buf |-> buf_full_q
    );

endmodule

// File: tb/tb_spi_tx.sv
// Self-checking bench for spi_tx: a bit-banged mode-0 controller plus a byte-queue model of the
// holding buffer that predicts the MISO byte stream and underrun count per transaction.
module tb_spi_tx;

    localparam int unsigned SYNC  = 2;
    localparam logic [7:0]  FILLV = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       csn = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       miso, oe, tx_ready, underrun, busy;

    always #5 clk = ~clk;

    spi_tx #(
        .SYNC_STAGES (SYNC),
        .FILL        (FILLV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_sck_i     (sck),
        .spi_csn_i     (csn),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (oe),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .underrun_o    (underrun),
        .busy_o        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the holding buffer is a queue of at most one byte, consumed at each byte's first rise.
    logic [7:0] mdl_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         refill_en[$];
    logic [7:0] refill_dat[$];
    int         exp_ur;
    int         nbits;
    int         rise_no;
    logic [7:0] cur;
    logic [3:0] partial;

    int ur_cnt = 0;
    int ur_at  = 0;

    always @(negedge clk) begin
        if (underrun === 1'b1) begin
            ur_cnt = ur_cnt + 1;
            ur_at  = rise_no;
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ready: tx_ready=%b expected 1", tx_ready);
        end
        tx_data  = b;
        tx_valid = 1'b1;
        mdl_q.push_back(b);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        csn     = 1'b0;
        nbits   = 0;
        rise_no = 0;
        cur     = 8'h00;
        exp_ur  = 0;
        rx_q.delete();
        exp_q.delete();
        repeat (8) @(negedge clk);
        n_checks++;
        if (oe !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cs_active: oe=%b busy=%b expected 1 1", oe, busy);
        end
    endtask

    task automatic cs_high();
        csn = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (oe !== 1'b0 || busy !== 1'b0 || miso !== 1'b0) begin
            n_fail++;
            $display("FAIL cs_idle: oe=%b busy=%b miso=%b expected 0 0 0", oe, busy, miso);
        end
    endtask

    // Drives n sck periods of 8 clk each; samples MISO just before every rising edge.
    task automatic sck_bits(input int n);
        int slot;
        int bit_in;
        for (int i = 0; i < n; i++) begin
            slot   = nbits / 8;
            bit_in = nbits % 8;
            cur    = {cur[6:0], miso};
            sck    = 1'b1;
            rise_no++;
            if (bit_in == 0) begin
                if (mdl_q.size() > 0) begin
                    exp_q.push_back(mdl_q.pop_front());
                end else begin
                    exp_q.push_back(FILLV);
                    exp_ur++;
                end
            end
            repeat (3) @(negedge clk);
            if (bit_in == 0 && slot < refill_en.size() && refill_en[slot]) begin
                n_checks++;
                if (tx_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL refill_ready: slot %0d tx_ready=%b expected 1", slot, tx_ready);
                end
                tx_data  = refill_dat[slot];
                tx_valid = 1'b1;
                mdl_q.push_back(refill_dat[slot]);
                @(negedge clk);
                tx_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
            sck   = 1'b0;
            nbits = nbits + 1;
            if (nbits % 8 == 0) rx_q.push_back(cur);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({miso, oe, tx_ready, underrun, busy} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_outputs: miso,oe,ready,ur,busy=%b expected 00100",
                     {miso, oe, tx_ready, underrun, busy});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({oe, tx_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL post_reset: oe,ready,busy=%b expected 010", {oe, tx_ready, busy});
        end
    endtask

    task automatic test_single_byte();
        int ur0;
        refill_en.delete();
        refill_dat.delete();
        write_byte(8'hA5);
        ur0 = ur_cnt;
        cs_low();
        n_checks++;
        if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready_before: tx_ready=%b expected 0", tx_ready);
        end
        sck_bits(1);
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready_after_rise: tx_ready=%b expected 1", tx_ready);
        end
        sck_bits(7);
        cs_high();
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== exp_q[0] || exp_q[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_data: got %h expected %h", rx_q[0], 8'hA5);
        end
        n_checks++;
        if (ur_cnt - ur0 != 0) begin
            n_fail++;
            $display("FAIL single_underrun: pulses=%0d expected 0", ur_cnt - ur0);
        end
    endtask

    task automatic test_back_to_back();
        int ur0;
        refill_en.delete();
        refill_dat.delete();
        refill_en.push_back(1'b1);
        refill_dat.push_back(8'hC3);
        write_byte(8'h3C);
        ur0 = ur_cnt;
        cs_low();
        sck_bits(16);
        cs_high();
        n_checks++;
        if (rx_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d bytes expected 2", rx_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (ur_cnt - ur0 != 0) begin
            n_fail++;
            $display("FAIL b2b_underrun: pulses=%0d expected 0", ur_cnt - ur0);
        end
    endtask

    task automatic test_underrun();
        int ur0;
        refill_en.delete();
        refill_dat.delete();
        ur0 = ur_cnt;
        cs_low();
        sck_bits(8);
        cs_high();
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== FILLV) begin
            n_fail++;
            $display("FAIL underrun_data: got %h expected %h", rx_q[0], FILLV);
        end
        n_checks++;
        if (ur_cnt - ur0 != 1 || ur_at != 1) begin
            n_fail++;
            $display("FAIL underrun_pulse: pulses=%0d at_rise=%0d expected 1 at 1",
                     ur_cnt - ur0, ur_at);
        end
    endtask

    task automatic test_abort_before_sck();
        refill_en.delete();
        refill_dat.delete();
        write_byte(8'h81);
        cs_low();
        cs_high();
        n_checks++;
        if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_keep_ready: tx_ready=%b expected 0", tx_ready);
        end
        cs_low();
        sck_bits(8);
        cs_high();
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== exp_q[0] || exp_q[0] !== 8'h81) begin
            n_fail++;
            $display("FAIL abort_resend: got %h expected %h", rx_q[0], 8'h81);
        end
    endtask

    task automatic test_abort_mid_byte();
        refill_en.delete();
        refill_dat.delete();
        write_byte(8'hF0);
        cs_low();
        sck_bits(4);
        partial = cur[3:0];
        cs_high();
        n_checks++;
        if (partial !== 4'hF) begin
            n_fail++;
            $display("FAIL midabort_partial: got %h expected f", partial);
        end
        write_byte(8'h55);
        cs_low();
        sck_bits(8);
        cs_high();
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== exp_q[0] || exp_q[0] !== 8'h55) begin
            n_fail++;
            $display("FAIL midabort_next: got %h expected %h", rx_q[0], 8'h55);
        end
    endtask

    task automatic test_random();
        int nb;
        int ur0;
        for (int t = 0; t < 5; t++) begin
            nb = $urandom_range(1, 3);
            refill_en.delete();
            refill_dat.delete();
            for (int s = 0; s < nb; s++) begin
                refill_en.push_back(1'($urandom_range(0, 1)));
                refill_dat.push_back(8'($urandom));
            end
            if (mdl_q.size() == 0 && $urandom_range(0, 1) == 1) write_byte(8'($urandom));
            ur0 = ur_cnt;
            cs_low();
            sck_bits(8 * nb);
            cs_high();
            n_checks++;
            if (rx_q.size() != nb) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d expected %0d", t, rx_q.size(), nb);
            end else begin
                for (int i = 0; i < nb; i++) begin
                    n_checks++;
                    if (rx_q[i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_data[%0d]: got %h expected %h",
                                 t, i, rx_q[i], exp_q[i]);
                    end
                end
            end
            n_checks++;
            if (ur_cnt - ur0 != exp_ur) begin
                n_fail++;
                $display("FAIL rand%0d_underrun: pulses=%0d expected %0d", t, ur_cnt - ur0, exp_ur);
            end
        end
    endtask

    task automatic test_async_reset();
        refill_en.delete();
        refill_dat.delete();
        if (mdl_q.size() == 0) write_byte(8'($urandom));
        cs_low();
        sck_bits(4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({miso, oe, tx_ready, underrun, busy} !== 5'b00100) begin
            n_fail++;
            $display("FAIL async_reset: miso,oe,ready,ur,busy=%b expected 00100",
                     {miso, oe, tx_ready, underrun, busy});
        end
        mdl_q.delete();
        csn = 1'b1;
        sck = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1 || oe !== 1'b0) begin
            n_fail++;
            $display("FAIL async_release: ready=%b oe=%b expected 1 0", tx_ready, oe);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_underrun();
        test_abort_before_sck();
        test_abort_mid_byte();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
